// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the shared resource arbiter
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  localparam int DEFAULT_MAX_HOLD = 16;

  // Width of a pointer/owner index into n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Finds the first set, non-excluded request searching upward from start, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int  N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(start) + i;
      if (j >= N) j = j - N;
      if (!valid && req[j] && !excl[j]) begin
        valid     = 1'b1;
        idx       = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_resource_arbiter.sv
// rtl/shared_resource_arbiter.sv - round-robin owner of a resource shared by N pipelines
// Define ARB_TIMEOUT_EN to force a handoff after MAX_HOLD cycles when others wait.
module shared_resource_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  output logic [N_REQ-1:0]          grant,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [DATA_W-1:0]         res_in,
  input  logic [DATA_W-1:0]         res_out,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      busy,
  output logic [idx_w(N_REQ)-1:0]   owner,
  output logic                      timeout_pulse
);

  localparam int IW = idx_w(N_REQ);

  if (N_REQ < 2 || N_REQ > 16) begin : g_nreq_chk
    $error("N_REQ must be within 2..16");
  end
  if (MAX_HOLD < 2) begin : g_hold_chk
    $error("MAX_HOLD must be at least 2");
  end

  arb_state_t       state, state_nxt;
  logic [IW-1:0]    ptr, ptr_nxt, owner_nxt;
  logic [N_REQ-1:0] grant_nxt, pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid, take, timeout_take, timeout_hit, owner_req;

  assign owner_req = req[owner];

  // Excluding the current grant lets the same picker serve both release and timeout handoff.
  rr_pick #(.N(N_REQ)) u_pick (
    .req    (req),
    .start  (ptr),
    .excl   (grant),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    owner_nxt    = owner;
    ptr_nxt      = ptr;
    take         = 1'b0;
    timeout_take = 1'b0;
    case (state)
      ARB_IDLE: take = pick_valid;
      ARB_OWNED: begin
        if (!owner_req) begin
          if (pick_valid) begin
            take = 1'b1;
          end else begin
            state_nxt = ARB_IDLE;
            grant_nxt = '0;
          end
        end else if (timeout_hit && pick_valid) begin
          take         = 1'b1;
          timeout_take = 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (take) begin
      state_nxt = ARB_OWNED;
      grant_nxt = pick_onehot;
      owner_nxt = pick_idx;
      ptr_nxt   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB_IDLE;
      grant <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);
  logic [CW-1:0] hold_cnt;

  assign timeout_hit = (hold_cnt == CW'(MAX_HOLD - 1));

  // Saturates at MAX_HOLD-1 while the owner is alone; any grant change restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout_take;
      if (grant_nxt != grant)
        hold_cnt <= '0;
      else if (state == ARB_OWNED && owner_req && !timeout_hit)
        hold_cnt <= hold_cnt + CW'(1);
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  assign busy      = |grant;
  assign res_in    = (state == ARB_OWNED) ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;
  assign resp_data = res_out;

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// tb/tb_shared_resource_arbiter.sv - scoreboard bench for shared_resource_arbiter
// Stimulus pushes model predictions; a negedge monitor pops and compares.
module tb_shared_resource_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [DW-1:0]   res_out = '0;
  logic [N-1:0]    grant;
  logic [DW-1:0]   res_in, resp_data;
  logic            busy, timeout_pulse;
  logic [1:0]      owner;

  shared_resource_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .grant         (grant),
    .req_data      (req_data),
    .res_in        (res_in),
    .res_out       (res_out),
    .resp_data     (resp_data),
    .busy          (busy),
    .owner         (owner),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  grant;
    int            owner;
    logic          busy;
    logic          pulse;
    logic [DW-1:0] res_in;
    logic [DW-1:0] resp;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  // Reference model: who owns the resource, where the search starts, how long held.
  bit m_busy;
  int m_owner, m_ptr, m_cnt;
  bit m_pulse;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int excl);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (m_ptr + i) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_pulse = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    int w;
    bit tk;
    w = -1; tk = 0; m_pulse = 0;
    if (!m_busy) begin
      w = pick(r, -1); tk = (w >= 0);
    end else if (!r[m_owner]) begin
      w = pick(r, m_owner); tk = (w >= 0);
      if (!tk) begin m_busy = 0; m_cnt = 0; end
    end else if (TO_EN && m_cnt == MH - 1) begin
      w = pick(r, m_owner); tk = (w >= 0); m_pulse = tk;
    end else if (TO_EN) begin
      m_cnt++;
    end
    if (tk) begin
      m_busy = 1; m_owner = w; m_ptr = (w + 1) % N; m_cnt = 0;
    end
  endtask

  function automatic exp_t predict();
    exp_t x;
    x.grant  = m_busy ? N'(1 << m_owner) : '0;
    x.owner  = m_owner;
    x.busy   = m_busy;
    x.pulse  = m_pulse;
    x.res_in = m_busy ? req_data[m_owner*DW +: DW] : '0;
    x.resp   = res_out;
    return x;
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                       input logic [DW-1:0] ro, input bit rel = 1'b0);
    @(negedge clk);
    #1;
    if (rel) reset = 1'b1;
    req = r; req_data = d; res_out = ro;
    model_step(r);
    q.push_back(predict());
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    q.delete();
    model_reset();
    #1;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_owner", 64'(owner), 64'(0));
    check("rst_pulse", 64'(timeout_pulse), 64'(0));
  endtask

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      check("grant", 64'(grant), 64'(e.grant));
      check("owner", 64'(owner), 64'(e.owner));
      check("busy", 64'(busy), 64'(e.busy));
      check("timeout_pulse", 64'(timeout_pulse), 64'(e.pulse));
      check("res_in", 64'(res_in), 64'(e.res_in));
      check("resp_data", 64'(resp_data), 64'(e.resp));
    end
  end

  initial begin
    logic [N*DW-1:0] pat;
    logic [N-1:0]    r;
    pat = {32'hD3, 32'hC2, 32'hB1, 32'hA0};

    // Reset with every pipeline requesting: grant must stay low until release.
    req = 4'b1111;
    #2;
    assert_reset();
    repeat (3) begin
      @(negedge clk);
      check("grant_in_reset", 64'(grant), 64'(0));
    end
    drive(4'b1111, pat, 32'h55, 1'b1);

    // Each owner drops for one cycle: zero-gap rotation 0001->0010->0100->1000->0001.
    drive(4'b1110, pat, 32'h55);
    drive(4'b1101, pat, 32'h55);
    drive(4'b1011, pat, 32'h55);
    drive(4'b0111, pat, 32'h55);
    drive(4'b0000, pat, 32'h55);
    drive(4'b0000, pat, 32'h12);

    // Pipeline 1 holds while pipeline 3 waits.
    @(negedge clk);
    assert_reset();
    drive(4'b0010, rand_data(), $urandom, 1'b1);
    repeat (10) drive(4'b1010, rand_data(), $urandom);
    drive(4'b0000, rand_data(), $urandom);

    // A lone requester keeps the grant indefinitely.
    repeat (20) drive(4'b0100, rand_data(), $urandom);

    // Asynchronous reset in the middle of a grant, then pointer restarts at 0.
    @(posedge clk);
    #2;
    assert_reset();
    drive(4'b1100, pat, 32'h0, 1'b1);
    drive(4'b1100, pat, 32'h0);

    // Randomised sticky requests.
    @(negedge clk);
    assert_reset();
    r = 4'($urandom);
    drive(r, rand_data(), $urandom, 1'b1);
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      drive(r, rand_data(), $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shared_resource_arbiter.md
# shared_resource_arbiter

Round-robin arbiter that sits directly downstream of N pipeline instances and owns their shared resource. It collects each pipeline's `arbiter_req` and `resource_input`, returns `arbiter_grant`, and steers the selected pipeline's data to the resource. The resource's result is broadcast back as `resource_output`. Only the granted pipeline treats that result as valid.

## Interface
Parameters:
- `N_REQ`, 4: number of requesting pipelines, 2..16.
- `DATA_W`, 32: resource data width.
- `MAX_HOLD`, 16: maximum consecutive grant cycles before forced handoff. Used only with `ARB_TIMEOUT_EN`; must be ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-pipeline `arbiter_req`.
- `grant`  out  N_REQ  per-pipeline `arbiter_grant`, one-hot or zero, registered.
- `req_data`  in  N_REQ*DATA_W  concatenated `resource_input`; slice i belongs to pipeline i.
- `res_in`  out  DATA_W  data to the shared resource.
- `res_out`  in  DATA_W  result from the shared resource.
- `resp_data`  out  DATA_W  broadcast `resource_output` to all pipelines.
- `busy`  out  1  high while any grant is held.
- `owner`  out  $clog2(N_REQ)  index of the current grantee; holds its last value when idle.
- `timeout_pulse`  out  1  one-cycle strobe on a forced handoff.

## Operation
- States: IDLE (no grant) and OWNED (exactly one grant bit set).
- Winner selection: the first set `req` bit searching upward from `ptr`, wrapping modulo N_REQ.
- After every grant, `ptr` is set to the winner + 1 (mod N_REQ).
- IDLE:
  - Any `req` set → OWNED; grant the winner.
  - No `req` set → stay in IDLE.
- OWNED, owner's `req` low (release):
  - Other requests pending → grant the next winner at the same edge, with no idle gap.
  - No other requests → IDLE, `grant` = 0.
- OWNED, owner's `req` high → hold the grant, subject to the timeout rule in Configuration.
- A newly asserted `req` never preempts the current owner except through timeout.
- `res_in`:
  - OWNED → combinational `req_data` slice of `owner`.
  - IDLE → all zeros.
- `resp_data` = `res_out`, combinational pass-through.

## Timing
- Reset (async assert): `grant`=0, `busy`=0, `owner`=0, `timeout_pulse`=0, `ptr`=0, hold counter=0, state=IDLE.
- Reset deassertion is synchronised externally. The first edge after release evaluates `req` normally.
- Request-to-grant latency: 1 cycle.
  - `req` first high before edge k → `grant` high after edge k.
- Release-to-drop latency: 1 cycle.
  - `req` low before edge k → `grant` low or moved after edge k.
- The pipeline may drive `resource_input` only while its `grant` is high.
- Simultaneous requests from IDLE: the lowest index ≥ `ptr` wins. After reset, pipeline 0 has top priority.
- Reset asserted mid-grant: `grant` drops immediately (asynchronous) and the in-flight resource transaction is abandoned.
- `busy` = OR of `grant`; `owner` is updated at the same edge as `grant`.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A hold counter increments every OWNED cycle while the owner keeps `req` high.
  - When the counter reaches MAX_HOLD−1 and another `req` is pending, the grant moves to the next winner at that edge. `timeout_pulse` is high for that one cycle and the counter clears.
  - When the counter reaches MAX_HOLD−1 with no other requester, the counter saturates and the owner keeps the grant.
  - The counter clears on every grant change.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and `timeout_pulse` is tied to 0.
  - The owner holds the grant until it releases.

## Structure
- Package `arb_pkg`:
  - state enum `ARB_IDLE` / `ARB_OWNED`;
  - `ptr`/`owner` index width function;
  - default `MAX_HOLD` constant.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, start pointer, exclude mask.
  - Outputs: one-hot winner, winner index, valid.
  - Instantiated once.

## Test plan
- Reset with `req`=4'b1111 held → `grant`=0 during reset; first edge after release gives `grant`=4'b0001, `owner`=0.
- `req`=4'b1111 held, each owner drops its `req` for one cycle after grant → grant sequence 0001, 0010, 0100, 1000, 0001 with zero-cycle handoff gaps.
- `res_in` mirroring:
  - `req_data` slices = 0xA0, 0xB1, 0xC2, 0xD3 and pipeline 2 granted → `res_in`=0xC2.
  - `res_out`=0x55 → `resp_data`=0x55.
  - IDLE → `res_in`=0.
- `ARB_TIMEOUT_EN`, `MAX_HOLD`=4: pipeline 1 holds, pipeline 3 requests → after 4 grant cycles `grant`=1000 and `timeout_pulse` high for exactly 1 cycle.
- `ARB_TIMEOUT_EN`, lone requester held 20 cycles → grant stays and `timeout_pulse` never fires.
- Reset asserted mid-grant → `grant`=0 asynchronously; after release `ptr`=0, so `req`=4'b1100 gives `grant`=0100.
